boa_extmem_arbiter: RTL
=======================

# boa_extmem_arbiter

Two-port arbiter that shares one `boa_mem_bus` slave, typically the 8-bit external SRAM controller, between two requesters such as instruction fetch and data access. It sits between the two CPU-side buses and the single downstream slave port. It forwards the selected requester combinationally, so it adds no latency to the downstream access. When one transfer completes and the other requester is waiting, ownership passes to it with no idle cycle.

## Interface
Parameters:
- None. Address and data widths come from `boa_mem_bus`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `m0` `boa_mem_bus.MEM`: requester port 0 (`re` 1, `we` 4, `addr`, `wdata` 32, `rdata` 32, `ready` 1).
- `m1` `boa_mem_bus.MEM`: requester port 1, same signals as `m0`.
- `s` `boa_mem_bus.CPU`: downstream port to the shared slave.
- `owner` out 1: requester currently holding `s`; valid when `busy`=1.
- `busy` out 1: a downstream transfer is in flight.

## Operation
Bus protocol, used on all three ports:
- A transfer is accepted at the first clock edge where `re`|`we` is sampled high.
- It completes at the first later edge where `ready`=1 is sampled.
- `rdata` is valid in the completion cycle.
- The requester holds `re`, `we`, `addr` and `wdata` stable from presentation through the completion edge, then deasserts, or presents a new request.
- Dropping a request before completion is a protocol violation; behaviour is undefined.

State machine: IDLE, BUSY.
- **IDLE:**
  - Winner is selected combinationally from the requesting ports; the winner's signals drive `s`.
  - At the edge: if any request is present, go to BUSY with `owner`←winner and record the last grant.
  - If no port is requesting, `s.re`=0 and `s.we`=0.
- **BUSY, `s.ready`=0:** `s` carries `m[owner]` signals.
- **BUSY, `s.ready`=1 (completion cycle):**
  - `m[owner].ready`=1.
  - `s` carries the *other* port's request if it is requesting: handover, stay BUSY, `owner` flips.
  - Otherwise `s.re`=`s.we`=0 and go to IDLE.
  - The completing owner is never re-forwarded in its own completion cycle, so the slave cannot sample a stale repeat.

Per-port `ready`:
- 1 while the port is not requesting.
- 0 from the cycle after acceptance until its completion cycle.
- A port that requested in the same cycle as the winner is treated as accepted (its presentation edge counts) and holds `ready`=0 until its own completion.

Data and reset:
- `rdata` is broadcast: `m0.rdata`=`m1.rdata`=`s.rdata`.
- Reset values: state IDLE, `busy`=0, `owner`=0, last-grant=1, `m0.ready`=`m1.ready`=1.
- While `rst`=1, `s.re`=0 and `s.we`=0.
- Reset mid-transfer aborts the transfer immediately; the slave is expected to be reset in the same cycle.

## Timing
- Added latency: 0 cycles. Downstream accept happens on the same edge as the upstream accept of the winner.
- Handover bubble: 0 cycles. The loser's downstream accept edge is the owner's completion edge.
- Losing requester's total latency: its own access time plus the remaining time of the current access.
- `owner` and `busy` are registered. `s` request signals, upstream `ready` and `rdata` are combinational.
- Worst case with both ports saturating: strict alternation, one access each.

## Configuration
Macro: `BOA_EXTMEM_ARBITER_RR_EN`.
- **Defined:** round-robin. On a tie in IDLE, the port not granted last wins; after reset, `m0` wins the first tie.
- **Undefined:** fixed priority. `m0` always wins ties in IDLE. Handover at completion still goes to the other port when it is requesting, so `m1` cannot be starved by back-to-back `m0` requests separated by a completion.

## Test plan
Downstream model for all scenarios: `ready` low for 3 cycles after accept, then high for one cycle, `rdata`=`addr`^`0xA5A5A5A5`.
- `m0` reads 0x10 alone → `s.addr`=0x10 on the accept edge; `m0.ready` 1,0,0,0,1; `rdata`=0xA5A5A5B5 in the completion cycle; `busy` returns to 0.
- `m0` read 0x20 and `m1` write 0x30/`we`=0xF/`wdata`=0xDEADBEEF presented in the same cycle → `m0` served first (both configs after reset); `s` switches to the `m1` write in the `m0` completion cycle; slave sees the write at 0x30 on that edge; `owner` 0→1.
- RR build, both ports requesting continuously for 6 transfers → grant order 0,1,0,1,0,1; each port's `ready` is high only in its own completion cycles.
- Fixed-priority build, `m0` requesting continuously and `m1` requesting once → `m1` granted at the first `m0` completion, not starved.
- `m1` completes with no other request → `s.re`=`s.we`=0 in the completion cycle; state IDLE next cycle; slave sees exactly one access.
- `rst` asserted 2 cycles into a BUSY transfer → next cycle `busy`=0, `owner`=0, both upstream `ready`=1, `s.re`=`s.we`=0 throughout reset.

Source files
------------

// File: rtl/boa_extmem_arbiter_if.sv
// boa_mem_bus: simple request/ready memory bus shared by CPU-side masters and memory slaves.
// MEM is the slave-side view (receives requests), CPU is the master-side view (issues requests).
interface boa_mem_bus #(
    parameter int ADDR_W = 32
);
    logic              re;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport MEM (input re, input we, input addr, input wdata, output rdata, output ready);
    modport CPU (output re, output we, output addr, output wdata, input rdata, input ready);
endinterface

// File: rtl/boa_extmem_arbiter.sv
// Two-requester arbiter in front of one boa_mem_bus slave, zero added latency, zero-bubble handover.
// Define BOA_EXTMEM_ARBITER_RR_EN for round-robin ties in IDLE; otherwise m0 wins ties.
module boa_extmem_arbiter (
    input  logic    clk,
    input  logic    rst,
    boa_mem_bus.MEM m0,
    boa_mem_bus.MEM m1,
    boa_mem_bus.CPU s,
    output logic    owner,
    output logic    busy
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   r_last;
    logic   w_owner_nxt;
    logic   w_last_nxt;
    logic   w_req0;
    logic   w_req1;
    logic   w_tie_pick;
    logic   w_win;
    logic   w_other_req;
    logic   w_sel;
    logic   w_fwd;

    assign w_req0 = m0.re | (|m0.we);
    assign w_req1 = m1.re | (|m1.we);

`ifdef BOA_EXTMEM_ARBITER_RR_EN
    assign w_tie_pick = ~r_last;
`else
    assign w_tie_pick = 1'b0;
`endif

    assign w_win       = (w_req0 & w_req1) ? w_tie_pick : w_req1;
    assign w_other_req = r_owner ? w_req0 : w_req1;

    // In the completion cycle the owner is never re-forwarded, so the slave cannot see a stale repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_sel       = r_owner;
        w_fwd       = 1'b0;
        case (r_state)
            IDLE: begin
                w_sel = w_win;
                w_fwd = w_req0 | w_req1;
                if (w_req0 | w_req1) begin
                    w_state_nxt = BUSY;
                    w_owner_nxt = w_win;
                    w_last_nxt  = w_win;
                end
            end
            BUSY: begin
                if (s.ready) begin
                    w_sel = ~r_owner;
                    w_fwd = w_other_req;
                    if (w_other_req) begin
                        w_owner_nxt = ~r_owner;
                        w_last_nxt  = ~r_owner;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_fwd = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign s.re    = w_fwd & ~rst & (w_sel ? m1.re : m0.re);
    assign s.we    = (w_fwd & ~rst) ? (w_sel ? m1.we : m0.we) : 4'h0;
    assign s.addr  = w_sel ? m1.addr : m0.addr;
    assign s.wdata = w_sel ? m1.wdata : m0.wdata;

    // A waiting non-owner counts as accepted and sees ready low until its own completion.
    assign m0.ready = (r_state == IDLE) ? 1'b1 : (!r_owner ? s.ready : !w_req0);
    assign m1.ready = (r_state == IDLE) ? 1'b1 : (r_owner ? s.ready : !w_req1);

    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;

    // busy is the FSM state itself.
    assign busy  = (r_state == BUSY);
    assign owner = r_owner;
endmodule
